// File: rtl/mac_sched_pkg.sv
`default_nettype none
// ============================================================================
// mac_sched_pkg : FSM state type and round-robin pick helper for mac_sched
// Rev 1.0
// ============================================================================
package mac_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // First set bit of mask strictly after ptr, wrapping modulo n (n <= 16).
    function automatic logic [3:0] rr_pick(
        input logic [15:0] mask,
        input logic [3:0]  ptr,
        input logic [4:0]  n
    );
        logic [3:0] pick;
        logic       found;
        logic [4:0] idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            idx = 5'(ptr) + 5'(i);
            if (idx >= n) idx = idx - n;
            if (!found && (5'(i) <= n) && (idx < 5'd16) && mask[idx[3:0]]) begin
                pick  = idx[3:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_sched_dp.sv
`default_nettype none
// ============================================================================
// mac_sched_dp : signed product + accumulate with overflow detect; clamps when MAC_SCHED_SATURATE_EN
// Rev 1.0
// ============================================================================
module mac_sched_dp #(
    parameter int LEN   = 9,
    parameter int ACC_W = 2*LEN
) (
    input  logic [ACC_W-1:0] acc_in,
    input  logic             ovf_in,
    input  logic [LEN-1:0]   in1,
    input  logic [LEN-1:0]   in2,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf_out
);

    logic signed [2*LEN-1:0] prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic        [ACC_W-1:0] sum;
    logic                    add_ovf;

    assign prod     = (2*LEN)'($signed(in1)) * (2*LEN)'($signed(in2));
    assign prod_ext = ACC_W'(prod);
    assign sum      = acc_in + prod_ext;
    assign add_ovf  = (acc_in[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_in[ACC_W-1]);
    assign ovf_out  = ovf_in | add_ovf;

`ifdef MAC_SCHED_SATURATE_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Once clamped the accumulator is frozen for the rest of the vector.
    always_comb begin
        acc_out = sum;
        if (ovf_in) begin
            acc_out = acc_in;
        end else if (add_ovf) begin
            acc_out = acc_in[ACC_W-1] ? ACC_MIN : ACC_MAX;
        end
    end
`else
    assign acc_out = sum;
`endif

endmodule
`default_nettype wire

// File: rtl/mac_sched.sv
`default_nettype none
// ============================================================================
// mac_sched : round-robin sequencer sharing one signed MAC (MAC_SCHED_SATURATE_EN = clamp on overflow)
// Rev 1.0
// ============================================================================
module mac_sched
    import mac_sched_pkg::*;
#(
    parameter int LEN     = 9,
    parameter int NUM_REQ = 4,
    parameter int ACC_W   = 2*LEN,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*LEN-1:0] req_in1,
    input  logic [NUM_REQ*LEN-1:0] req_in2,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ACC_W-1:0]       res_data,
    output logic [ID_W-1:0]        res_id,
    output logic                   res_overflow
);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   ptr_q,   ptr_d;
    logic [ACC_W-1:0]  acc_q,   acc_d;
    logic              ovf_q,   ovf_d;
    logic [ACC_W-1:0]  dp_acc;
    logic              dp_ovf;
    logic [LEN-1:0]    sel_in1, sel_in2;
    logic              beat;

    assign sel_in1 = req_in1[grant_q*LEN +: LEN];
    assign sel_in2 = req_in2[grant_q*LEN +: LEN];
    assign beat    = (state_q == ACC) && req_valid[grant_q];

    mac_sched_dp #(
        .LEN   (LEN),
        .ACC_W (ACC_W)
    ) u_dp (
        .acc_in  (acc_q),
        .ovf_in  (ovf_q),
        .in1     (sel_in1),
        .in2     (sel_in2),
        .acc_out (dp_acc),
        .ovf_out (dp_ovf)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_d = ID_W'(rr_pick(16'(req_valid), 4'(ptr_q), 5'(NUM_REQ)));
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ACC;
                end
            end
            ACC: begin
                req_ready[grant_q] = 1'b1;
                if (beat) begin
                    acc_d = dp_acc;
                    ovf_d = dp_ovf;
                    if (req_last[grant_q]) state_d = DONE;
                end
            end
            DONE: begin
                // Pointer advances only on handshake so a stalled result keeps its slot.
                if (res_ready) begin
                    ptr_d   = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= ID_W'(NUM_REQ - 1);
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign res_valid    = (state_q == DONE);
    assign res_data     = acc_q;
    assign res_id       = grant_q;
    assign res_overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_sched.sv
`default_nettype none
// ============================================================================
// tb_mac_sched : randomized self-checking bench for mac_sched against a dot-product model
// Rev 1.0
// ============================================================================
module tb_mac_sched;

    localparam int LEN     = 9;
    localparam int NUM_REQ = 4;
    localparam int ACC_W   = 18;
    localparam int ID_W    = 2;
    localparam longint AMAX = (64'sd1 <<< (ACC_W-1)) - 64'sd1;
    localparam longint AMIN = -(64'sd1 <<< (ACC_W-1));

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*LEN-1:0] req_in1;
    logic [NUM_REQ*LEN-1:0] req_in2;
    logic [NUM_REQ-1:0]     req_last;
    logic                   res_valid;
    logic                   res_ready;
    logic [ACC_W-1:0]       res_data;
    logic [ID_W-1:0]        res_id;
    logic                   res_overflow;

    int checks   = 0;
    int failures = 0;
    int va[NUM_REQ][16];
    int vb[NUM_REQ][16];
    int vlen[NUM_REQ];
    int model_ptr;

    always #5 clk = ~clk;

    mac_sched #(
        .LEN     (LEN),
        .NUM_REQ (NUM_REQ),
        .ACC_W   (ACC_W),
        .ID_W    (ID_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_in1      (req_in1),
        .req_in2      (req_in2),
        .req_last     (req_last),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_id       (res_id),
        .res_overflow (res_overflow)
    );

    // Dot product with exact arithmetic; overflow = any partial sum outside the ACC_W range.
    task automatic model_vec(input int i, output logic signed [ACC_W-1:0] r, output logic o);
        longint acc;
        longint s;
        logic signed [ACC_W-1:0] t;
        acc = 0;
        o   = 1'b0;
        for (int k = 0; k < vlen[i]; k++) begin
            s = acc + longint'(va[i][k]) * longint'(vb[i][k]);
            if (s > AMAX || s < AMIN) begin
                o = 1'b1;
`ifdef MAC_SCHED_SATURATE_EN
                acc = (s > AMAX) ? AMAX : AMIN;
                break;
`else
                t   = s[ACC_W-1:0];
                acc = longint'(t);
`endif
            end else begin
                acc = s;
            end
        end
        r = acc[ACC_W-1:0];
    endtask

    function automatic int rr_model(input bit got_in[NUM_REQ]);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int j;
            j = (model_ptr + k) % NUM_REQ;
            if (vlen[j] > 0 && !got_in[j]) return j;
        end
        return 0;
    endfunction

    task automatic clear_vecs();
        for (int i = 0; i < NUM_REQ; i++) vlen[i] = 0;
    endtask

    task automatic rand_vec(input int i, input int len);
        vlen[i] = len;
        for (int k = 0; k < len; k++) begin
            va[i][k] = int'($urandom_range(0, 511)) - 256;
            vb[i][k] = int'($urandom_range(0, 511)) - 256;
        end
    endtask

    task automatic apply_reset(input string tag);
        reset_n   = 1'b0;
        req_valid = '0;
        res_ready = 1'b0;
        #1;
        checks++; if (req_ready !== '0)   begin failures++; $display("FAIL %s req_ready got=%b exp=0", tag, req_ready); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL %s res_valid got=%b exp=0", tag, res_valid); end
        checks++; if (res_data !== '0)    begin failures++; $display("FAIL %s res_data got=%0d exp=0", tag, $signed(res_data)); end
        checks++; if (res_id !== '0)      begin failures++; $display("FAIL %s res_id got=%0d exp=0", tag, res_id); end
        checks++; if (res_overflow !== 1'b0) begin failures++; $display("FAIL %s res_overflow got=%b exp=0", tag, res_overflow); end
        repeat (2) @(negedge clk);
        reset_n   = 1'b1;
        model_ptr = NUM_REQ - 1;
    endtask

    // Streams every loaded vector; bubbles only mid-vector so every pending requester is valid at grant time.
    task automatic run_batch(input int bub_pct, input int stall_min, input int stall_max);
        int idx[NUM_REQ];
        bit streamed[NUM_REQ];
        bit got[NUM_REQ];
        bit bubbled[NUM_REQ];
        int remaining, cyc, stall, exp_id;
        bit have_exp, last_prev, last_now, hs_prev, hs_now;
        logic signed [ACC_W-1:0] exp_d;
        logic exp_o;
        remaining = 0; cyc = 0; stall = 0; exp_id = 0; exp_d = '0; exp_o = 1'b0;
        have_exp = 0; last_prev = 0; hs_prev = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx[i] = 0; streamed[i] = 0; got[i] = 0; bubbled[i] = 0;
            if (vlen[i] > 0) remaining++;
        end
        while (remaining > 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            last_now = 0;
            hs_now   = 0;
            if (last_prev) begin
                checks++;
                if (res_valid !== 1'b1) begin failures++; $display("FAIL latency res_valid got=%b exp=1", res_valid); end
            end
            if (hs_prev) begin
                checks++;
                if (res_valid !== 1'b0) begin failures++; $display("FAIL res_valid_drop got=%b exp=0", res_valid); end
            end
            checks++;
            if ($countones(req_ready) > 1 || (res_valid === 1'b1 && req_ready !== '0)) begin
                failures++; $display("FAIL req_ready_grant got=%b res_valid=%b exp=onehot_or_zero", req_ready, res_valid);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (vlen[i] > 0 && !streamed[i]) begin
                    if (idx[i] > 0 && !bubbled[i] && int'($urandom_range(0, 99)) < bub_pct) begin
                        req_valid[i] = 1'b0; bubbled[i] = 1;
                    end else begin
                        req_valid[i] = 1'b1; bubbled[i] = 0;
                    end
                    req_in1[i*LEN +: LEN] = LEN'(va[i][idx[i]]);
                    req_in2[i*LEN +: LEN] = LEN'(vb[i][idx[i]]);
                    req_last[i] = (idx[i] == vlen[i] - 1);
                end else begin
                    req_valid[i] = 1'b0;
                    req_in1[i*LEN +: LEN] = LEN'($urandom);
                    req_in2[i*LEN +: LEN] = LEN'($urandom);
                    req_last[i] = 1'($urandom_range(0, 1));
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i] === 1'b1) begin
                    if (req_last[i]) begin streamed[i] = 1; last_now = 1; end
                    idx[i]++;
                end
            end
            if (res_valid === 1'b1) begin
                if (!have_exp) begin
                    exp_id = rr_model(got);
                    model_vec(exp_id, exp_d, exp_o);
                    stall = int'($urandom_range(stall_min, stall_max));
                    have_exp = 1;
                end
                checks++; if (res_id !== ID_W'(exp_id)) begin failures++; $display("FAIL res_id got=%0d exp=%0d", res_id, exp_id); end
                checks++; if (res_data !== exp_d) begin failures++; $display("FAIL res_data id=%0d got=%0d exp=%0d", exp_id, $signed(res_data), exp_d); end
                checks++; if (res_overflow !== exp_o) begin failures++; $display("FAIL res_overflow id=%0d got=%b exp=%b", exp_id, res_overflow, exp_o); end
                if (stall > 0) begin
                    res_ready = 1'b0; stall--;
                end else begin
                    res_ready = 1'b1; hs_now = 1; got[exp_id] = 1;
                    model_ptr = exp_id; remaining--; have_exp = 0;
                end
            end else begin
                res_ready = 1'($urandom_range(0, 1));
            end
            last_prev = last_now;
            hs_prev   = hs_now;
        end
        if (remaining > 0) begin
            checks++; failures++;
            $display("FAIL batch_timeout got=%0d_pending exp=0", remaining);
        end
        @(negedge clk);
        req_valid = '0;
        res_ready = 1'b0;
        if (hs_prev) begin
            checks++;
            if (res_valid !== 1'b0) begin failures++; $display("FAIL res_valid_drop got=%b exp=0", res_valid); end
        end
    endtask

    task automatic test_reset();
        apply_reset("reset");
    endtask

    task automatic test_single();
        clear_vecs();
        vlen[0] = 1; va[0][0] = 100; vb[0][0] = 88;
        run_batch(0, 0, 0);
    endtask

    task automatic test_bubble();
        clear_vecs();
        vlen[2] = 2;
        va[2][0] = 32;  vb[2][0] = -32;
        va[2][1] = -21; vb[2][1] = -231;
        run_batch(100, 0, 0);
    endtask

    task automatic test_overflow();
        clear_vecs();
        vlen[1] = 2;
        va[1][0] = -256; vb[1][0] = -256;
        va[1][1] = -256; vb[1][1] = -256;
        run_batch(0, 0, 1);
    endtask

    task automatic test_round_robin();
        apply_reset("rr_reset");
        clear_vecs();
        rand_vec(0, 1);
        rand_vec(1, 1);
        run_batch(0, 0, 2);
        clear_vecs();
        rand_vec(0, 1);
        rand_vec(1, 1);
        rand_vec(3, 1);
        run_batch(0, 0, 2);
    endtask

    task automatic test_backpressure();
        clear_vecs();
        rand_vec(1, 3);
        rand_vec(2, 3);
        run_batch(30, 5, 5);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            clear_vecs();
            for (int i = 0; i < NUM_REQ; i++)
                if ($urandom_range(0, 1) == 1) rand_vec(i, int'($urandom_range(1, 8)));
            if (vlen[0] == 0 && vlen[1] == 0 && vlen[2] == 0 && vlen[3] == 0) rand_vec(n % NUM_REQ, 4);
            run_batch(30, 0, 3);
        end
    endtask

    task automatic test_reset_mid();
        int cnt;
        int cyc;
        apply_reset("mid_pre");
        clear_vecs();
        vlen[0] = 4;
        for (int k = 0; k < 4; k++) begin
            va[0][k] = int'($urandom_range(1, 255));
            vb[0][k] = int'($urandom_range(1, 255));
        end
        cnt = 0;
        cyc = 0;
        while (cnt < 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            req_valid    = '0;
            req_valid[0] = 1'b1;
            req_in1[0 +: LEN] = LEN'(va[0][cnt]);
            req_in2[0 +: LEN] = LEN'(vb[0][cnt]);
            req_last[0] = 1'b0;
            if (req_ready[0] === 1'b1) cnt++;
        end
        if (cnt < 2) begin
            checks++; failures++;
            $display("FAIL mid_stream_timeout got=%0d_beats exp=2", cnt);
        end
        @(negedge clk);
        #2;
        apply_reset("mid_abort");
        run_batch(0, 0, 1);
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_in1   = '0;
        req_in2   = '0;
        req_last  = '0;
        res_ready = 1'b0;
        model_ptr = NUM_REQ - 1;
        clear_vecs();
        test_reset();
        test_single();
        test_bubble();
        test_overflow();
        test_round_robin();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
